// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control tokens shared with the transmit encoder, plus decoder FSM states
package tmds_pkg;

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } dec_state_t;

endpackage

// File: rtl/tmds_word_decode.sv
// rtl/tmds_word_decode.sv - combinational TMDS 10b word classifier and 8b data decoder
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] word,
  output logic       is_token,
  output logic [1:0] ctl,
  output logic [7:0] q
);

  logic [7:0] d;

  always_comb begin
    is_token = 1'b1;
    ctl      = 2'b00;
    case (word)
      TOKEN_00: ctl = 2'b00;
      TOKEN_01: ctl = 2'b01;
      TOKEN_10: ctl = 2'b10;
      TOKEN_11: ctl = 2'b11;
      default:  is_token = 1'b0;
    endcase
  end

  // bit 9 marks an inverted payload, bit 8 selects XOR versus XNOR chaining
  assign d = word[9] ? ~word[7:0] : word[7:0];

  always_comb begin
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - per-channel TMDS word aligner and decoder; TMDS_DEC_STATS_EN adds slip/relock counters
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_WAIT      = 16,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  din,
  output logic        bitslip,
  output logic        locked,
  output logic [7:0]  dout,
  output logic        de,
  output logic        c0,
  output logic        c1
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [15:0] slip_count,
  output logic [7:0]  relock_count
`endif
);

  localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
  localparam int WAIT_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(SLIP_WAIT + 1);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SEARCH_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(SEARCH_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_END  = HOLD_W'(SLIP_WAIT);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  logic [9:0]        din_q;
  logic              is_token;
  logic [1:0]        ctl;
  logic [7:0]        q;

  dec_state_t        state, state_n;
  logic [RUN_W-1:0]  run_cnt, run_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [LOSS_W-1:0] loss_cnt, loss_n;
  logic              slip_n;
  logic              timed_out;
  logic [7:0]        dout_n;
  logic              de_n;
  logic [1:0]        ctl_n;

  tmds_word_decode u_decode (
    .word     (din_q),
    .is_token (is_token),
    .ctl      (ctl),
    .q        (q)
  );

  assign timed_out = (wait_cnt >= WAIT_LAST);

  always_comb begin
    state_n = state;
    run_n   = run_cnt;
    wait_n  = wait_cnt;
    hold_n  = hold_cnt;
    loss_n  = loss_cnt;
    slip_n  = 1'b0;
    case (state)
      ST_SEARCH: begin
        run_n  = is_token ? run_cnt + 1'b1 : '0;
        // a token on the timeout word defers the slip, so the wait count parks at its limit
        wait_n = timed_out ? WAIT_MAX : wait_cnt + 1'b1;
        if (is_token && run_cnt == RUN_LAST) begin
          state_n = ST_LOCKED;
          run_n   = '0;
          wait_n  = '0;
          loss_n  = '0;
        end else if (!is_token && timed_out) begin
          state_n = ST_SLIP_WAIT;
          slip_n  = 1'b1;
          run_n   = '0;
          wait_n  = '0;
          hold_n  = '0;
        end
      end
      ST_SLIP_WAIT: begin
        if (hold_cnt == HOLD_END) begin
          state_n = ST_SEARCH;
          hold_n  = '0;
          run_n   = '0;
          wait_n  = '0;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        loss_n = is_token ? '0 : loss_cnt + 1'b1;
        if (!is_token && loss_cnt == LOSS_LAST) begin
          state_n = ST_SEARCH;
          loss_n  = '0;
          run_n   = '0;
          wait_n  = '0;
        end
      end
      default: state_n = ST_SEARCH;
    endcase
  end

  // outputs follow the lock status being registered alongside them
  always_comb begin
    dout_n = '0;
    de_n   = 1'b0;
    ctl_n  = 2'b00;
    if (state_n == ST_LOCKED) begin
      if (is_token) begin
        ctl_n = ctl;
      end else begin
        de_n   = 1'b1;
        dout_n = q;
        ctl_n  = {c1, c0};
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      din_q    <= '0;
      state    <= ST_SEARCH;
      run_cnt  <= '0;
      wait_cnt <= '0;
      hold_cnt <= '0;
      loss_cnt <= '0;
      bitslip  <= 1'b0;
      locked   <= 1'b0;
      dout     <= '0;
      de       <= 1'b0;
      c0       <= 1'b0;
      c1       <= 1'b0;
    end else begin
      din_q    <= din;
      state    <= state_n;
      run_cnt  <= run_n;
      wait_cnt <= wait_n;
      hold_cnt <= hold_n;
      loss_cnt <= loss_n;
      bitslip  <= slip_n;
      locked   <= (state_n == ST_LOCKED);
      dout     <= dout_n;
      de       <= de_n;
      c0       <= ctl_n[0];
      c1       <= ctl_n[1];
    end
  end

`ifdef TMDS_DEC_STATS_EN
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      slip_count   <= '0;
      relock_count <= '0;
    end else begin
      if (slip_n && slip_count != '1) begin
        slip_count <= slip_count + 1'b1;
      end
      if (state == ST_LOCKED && state_n == ST_SEARCH && relock_count != '1) begin
        relock_count <= relock_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - randomized self-checking bench with serial deserializer and behavioural decoder model
module tb_tmds_channel_decoder;

  localparam int TOKEN_RUN      = 8;
  localparam int SEARCH_TIMEOUT = 64;
  localparam int SLIP_WAIT      = 16;
  localparam int LOSS_TIMEOUT   = 4096;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk_pixel = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] din = '0;
  logic       bitslip, locked, de, c0, c1;
  logic [7:0] dout;
`ifdef TMDS_DEC_STATS_EN
  logic [15:0] slip_count;
  logic [7:0]  relock_count;
`endif

  always #5 clk_pixel = ~clk_pixel;

  tmds_channel_decoder #(
    .TOKEN_RUN      (TOKEN_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .SLIP_WAIT      (SLIP_WAIT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) dut (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .din          (din),
    .bitslip      (bitslip),
    .locked       (locked),
    .dout         (dout),
    .de           (de),
    .c0           (c0),
    .c1           (c1)
`ifdef TMDS_DEC_STATS_EN
    ,
    .slip_count   (slip_count),
    .relock_count (relock_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int token_index(input logic [9:0] w);
    logic [9:0] toks [4];
    toks = '{T00, T01, T10, T11};
    token_index = -1;
    for (int k = 0; k < 4; k++) if (w == toks[k]) token_index = k;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] d, q;
    d = w[9] ? ~w[7:0] : w[7:0];
    q = d ^ {d[6:0], 1'b0};
    if (!w[8]) q[7:1] = ~q[7:1];
    return q;
  endfunction

  // behavioural model: mode 0 hunting, 1 settling after a slip, 2 aligned
  int         m_mode, m_run, m_age, m_settle_left, m_quiet, m_slips, m_relocks;
  logic [1:0] m_c;
  logic [7:0] m_dout;
  logic       m_de, m_slip, m_lock;
  logic [9:0] m_dq, m_din_last;
  logic       rst_at_edge = 1'b1;

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_age = 0; m_settle_left = 0; m_quiet = 0;
    m_slips = 0; m_relocks = 0;
    m_c = '0; m_dout = '0; m_de = 1'b0; m_slip = 1'b0; m_lock = 1'b0;
  endtask

  task automatic model_step(input logic [9:0] w);
    int t;
    t = token_index(w);
    m_slip = 1'b0;
    if (m_mode == 0) begin
      m_run = (t >= 0) ? m_run + 1 : 0;
      m_age++;
      if (m_run >= TOKEN_RUN) begin
        m_mode = 2; m_quiet = 0;
      end else if (t < 0 && m_age >= SEARCH_TIMEOUT) begin
        m_mode = 1; m_slip = 1'b1; m_slips++; m_settle_left = SLIP_WAIT + 1;
      end
    end else if (m_mode == 1) begin
      m_settle_left--;
      if (m_settle_left == 0) begin
        m_mode = 0; m_run = 0; m_age = 0;
      end
    end else begin
      m_quiet = (t >= 0) ? 0 : m_quiet + 1;
      if (m_quiet >= LOSS_TIMEOUT) begin
        m_mode = 0; m_run = 0; m_age = 0; m_relocks++;
      end
    end
    m_lock = (m_mode == 2);
    if (!m_lock) begin
      m_c = '0; m_de = 1'b0; m_dout = '0;
    end else if (t >= 0) begin
      m_c = t[1:0]; m_de = 1'b0; m_dout = '0;
    end else begin
      m_de = 1'b1; m_dout = ref_decode(w);
    end
  endtask

  always @(posedge clk_pixel) rst_at_edge <= reset;

  initial forever begin
    @(negedge clk_pixel);
    if (reset || rst_at_edge) begin
      model_reset();
      m_dq = '0;
      m_din_last = din;
    end else begin
      model_step(m_dq);
      m_dq = m_din_last;
      m_din_last = din;
    end
`ifdef TMDS_DEC_STATS_EN
    chk("cycle_outputs", {slip_count, relock_count, bitslip, locked, de, c1, c0, dout},
        {16'(m_slips), 8'(m_relocks), m_slip, m_lock, m_de, m_c, m_dout});
`else
    chk("cycle_outputs", {bitslip, locked, de, c1, c0, dout},
        {m_slip, m_lock, m_de, m_c, m_dout});
`endif
  end

  // serial-link deserializer: leading fill bits set the word misalignment, each slip drops one bit
  bit sq[$];
  int cyc = 0;
  int slip_cycles[$];

  task automatic deser_init(input int pre);
    sq.delete();
    repeat (pre) sq.push_back(1'b0);
  endtask

  task automatic drive(input logic [9:0] w);
    logic [9:0] o;
    @(posedge clk_pixel);
    #1;
    cyc++;
    if (bitslip === 1'b1) begin
      slip_cycles.push_back(cyc);
      if (sq.size() > 0) void'(sq.pop_front());
    end
    for (int j = 0; j < 10; j++) sq.push_back(w[j]);
    for (int j = 0; j < 10; j++) o[j] = sq.pop_front();
    din = o;
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom);
    while (token_index(w) >= 0) w = 10'($urandom);
    return w;
  endfunction

  task automatic do_reset(input int pre);
    @(posedge clk_pixel);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {bitslip, locked, de, c1, c0, dout}, 13'd0);
    deser_init(pre);
    din = '0;
    @(posedge clk_pixel);
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ntok, tok8_cyc, lock_cyc, nrun, quiet_cyc, fall_cyc;
    deser_init(10);
    repeat (3) @(posedge clk_pixel);
    #1;
    chk("reset_state", {bitslip, locked, de, c1, c0, dout}, 13'd0);
    reset = 1'b0;

    // aligned token stream
    ntok = 0; tok8_cyc = -1; lock_cyc = -1;
    for (int i = 0; i < 22; i++) begin
      drive(T00);
      if (locked && lock_cyc < 0) lock_cyc = cyc;
      if (din == T00) ntok++;
      if (ntok == 8 && tok8_cyc < 0) tok8_cyc = cyc;
    end
    chk("lock_edge", 64'(lock_cyc), 64'(tok8_cyc + 2));
    chk("locked_after_tokens", locked, 1'b1);

    // data decode and control hold, 3 words of latency including the deserializer
    drive(10'b0111111111);
    drive(10'b1000000000);
    drive(T11);
    drive(10'b0111111111);
    chk("data_01", {de, c1, c0, dout}, {1'b1, 2'b00, 8'h01});
    drive(T00);
    chk("data_ff", {de, c1, c0, dout}, {1'b1, 2'b00, 8'hFF});
    drive(T00);
    chk("token_11", {de, c1, c0, dout}, {1'b0, 2'b11, 8'h00});
    drive(T00);
    chk("ctl_hold_11", {de, c1, c0, dout}, {1'b1, 2'b11, 8'h01});

    // random mix while locked
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: drive(T00);
          1: drive(T01);
          2: drive(T10);
          default: drive(T11);
        endcase
      end else begin
        drive(rand_data());
      end
    end
    drive(T00);
    drive(T00);
    chk("locked_after_mix", locked, 1'b1);

    // loss of lock after a long run of data words
    nrun = 0; quiet_cyc = -1; fall_cyc = -1;
    for (int i = 0; i < LOSS_TIMEOUT + 6; i++) begin
      drive(rand_data());
      if (token_index(din) < 0) nrun++; else nrun = 0;
      if (nrun == LOSS_TIMEOUT && quiet_cyc < 0) quiet_cyc = cyc;
      if (!locked && fall_cyc < 0) fall_cyc = cyc;
    end
    chk("lock_fall_edge", 64'(fall_cyc), 64'(quiet_cyc + 2));
    chk("unlocked_outputs", {locked, de, dout}, 10'd0);
`ifdef TMDS_DEC_STATS_EN
    chk("relock_count", relock_count, 8'd1);
    chk("slip_count_zero", slip_count, 16'd0);
`endif

    // misaligned link: three slips needed
    do_reset(13);
    slip_cycles.delete();
    lock_cyc = -1;
    for (int i = 0; i < 500; i++) begin
      drive(T00);
      if (locked && lock_cyc < 0) lock_cyc = cyc;
    end
    chk("slip_pulse_count", 64'(slip_cycles.size()), 64'd3);
    if (slip_cycles.size() >= 3) begin
      chk("slip_spacing_1", 64'(slip_cycles[1] - slip_cycles[0]), 64'd81);
      chk("slip_spacing_2", 64'(slip_cycles[2] - slip_cycles[1]), 64'd81);
      chk("lock_after_last_slip", 64'(lock_cyc > slip_cycles[2]), 64'd1);
    end
    chk("locked_after_slips", locked, 1'b1);
`ifdef TMDS_DEC_STATS_EN
    chk("slip_count", slip_count, 16'd3);
`endif

    // reset while locked
    do_reset(10);
    slip_cycles.delete();
    for (int i = 0; i < 40; i++) drive(T00);
    chk("relock_after_reset_no_slip", {64'(slip_cycles.size()), 64'(locked)}, {64'd0, 64'd1});

    // reset during slip settling
    do_reset(13);
    slip_cycles.delete();
    for (int i = 0; i < 200 && slip_cycles.size() == 0; i++) drive(T00);
    chk("slip_seen_before_reset", 64'(slip_cycles.size()), 64'd1);
    repeat (5) drive(T00);
    do_reset(10);
    slip_cycles.delete();
    for (int i = 0; i < 40; i++) drive(T00);
    chk("relock_after_slip_reset", {64'(slip_cycles.size()), 64'(locked)}, {64'd0, 64'd1});

    repeat (3) @(posedge clk_pixel);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the HDMI transmit path: one instance per TMDS channel, in the pixel clock domain, after a 10:1 deserializer that supplies 10-bit words.
- Recovers word alignment by searching for control-token runs and pulsing a bitslip request to the deserializer.
- Decodes TMDS 10b words to 8-bit pixel data plus de/c0/c1 and reports lock status.

Parameters:
- TOKEN_RUN, 8: consecutive control tokens required to declare lock.
- SEARCH_TIMEOUT, 1024: words without a qualifying token run before a bitslip is issued.
- SLIP_WAIT, 16: cycles ignored after a bitslip while the deserializer settles.
- LOSS_TIMEOUT, 4096: words without any control token, while locked, before lock is dropped.

Ports:
- clk_pixel  in  1  pixel-rate clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- din  in  10  parallel TMDS word from the deserializer, bit 0 first on the wire.
- bitslip  out  1  one-cycle pulse requesting a 1-bit rotation from the deserializer.
- locked  out  1  word alignment is established.
- dout  out  8  decoded pixel byte.
- de  out  1  data-enable; asserted for data words.
- c0  out  1  control bit 0 (HSYNC on the blue channel).
- c1  out  1  control bit 1 (VSYNC on the blue channel).

Behaviour:
- Reset is asynchronous: all outputs go to 0, the FSM enters SEARCH, and all counters clear. A reset asserted mid-operation aborts any pending slip or lock immediately.
- Pipeline: din registers into din_q. Token detection and decoding are combinational on din_q. Outputs register on the next edge, giving 2 cycles of latency from din to dout/de/c0/c1. The FSM evaluates din_q.
- Control tokens map to {c1,c0} as follows:
  - 10'b1101010100 = 00
  - 10'b0010101011 = 01
  - 10'b0101010100 = 10
  - 10'b1010101011 = 11
- Data decode:
  - d = din_q[9] ? ~din_q[7:0] : din_q[7:0].
  - q[0] = d[0].
  - For i = 1..7: q[i] = din_q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Outputs while locked:
  - Token word: de=0, {c1,c0} = token value, dout=0.
  - Any other word: de=1, dout=q, c0/c1 hold their last token values.
- Outputs while not locked: dout, de, c0 and c1 are forced to 0.
- FSM states and transitions:
  - SEARCH: run_cnt increments on each token and clears on each non-token; wait_cnt increments every word. When run_cnt reaches TOKEN_RUN, go to LOCKED and set locked=1 on the same edge. Otherwise, when wait_cnt reaches SEARCH_TIMEOUT, pulse bitslip for 1 cycle, clear counters and go to SLIP_WAIT.
  - SLIP_WAIT: count SLIP_WAIT cycles with bitslip=0, then return to SEARCH with counters cleared.
  - LOCKED: loss_cnt clears on every token and increments on every non-token. When loss_cnt reaches LOSS_TIMEOUT, go to SEARCH, set locked=0 and clear counters. No bitslip is issued in LOCKED.
- Simultaneous events: a token arriving on the cycle the search timeout would fire takes priority, so there is no slip and counters update per the token rule. Run threshold and timeout reached together resolves as lock.
- Counter widths are $clog2(limit+1). Counters never wrap because they are cleared on the terminal condition.
- bitslip is never asserted on two consecutive cycles.

Optional Feature:
- Macro: TMDS_DEC_STATS_EN.
- When defined, two extra ports are added:
  - slip_count out 16: number of bitslip pulses issued.
  - relock_count out 8: number of LOCKED-to-SEARCH transitions.
- Both counters saturate at all-ones, clear only on reset, and update on the same edge as the causing event.
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package tmds_pkg holds:
  - the four control-token constants, which the transmit encoder also uses;
  - the FSM state encoding (SEARCH, SLIP_WAIT, LOCKED).
- Natural sub-module: tmds_word_decode, purely combinational. It maps din_q to is_token, {c1,c0} and q[7:0], and is reused per channel and by bench models.

Test Plan:
- Aligned stream, 20 tokens 10'b1101010100 → locked=1 on the edge after the 8th token reaches din_q. Then outputs de=0, c1c0=00 with 2-cycle latency.
- Locked, din=10'b0111111111 → dout=8'h01, de=1. din=10'b1000000000 → dout=8'hFF, de=1. Each appears 2 cycles after input.
- Locked, din=10'b1010101011 then one data word → de=0 with c1c0=11, then de=1 with c1c0 still 11.
- Bench deserializer model rotates each word by 3 bits (slips applied per pulse), SEARCH_TIMEOUT=64, SLIP_WAIT=16:
  - bitslip pulses spaced exactly 81 cycles apart;
  - locked asserts after the correcting slip;
  - no further pulses occur.
- Locked, then 4096 consecutive data words → locked falls on the 4096th, de/dout forced to 0 thereafter; relock_count=1 with TMDS_DEC_STATS_EN.
- Reset asserted mid-LOCKED and mid-SLIP_WAIT → all outputs 0 asynchronously; after release, lock is reacquired from SEARCH with no stale bitslip pulse.
